// File: rtl/rob_pkg.sv
// Shared reorder-buffer types and sizes for rob_commit.
package rob_pkg;

  localparam int DEPTH  = 16;
  localparam int TAG_W  = 4;
  localparam int PREG_W = 7;
  localparam int XLEN   = 32;
  localparam int AREG_W = 5;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [AREG_W-1:0] areg;
    logic [PREG_W-1:0] prd;
    logic [PREG_W-1:0] old_prd;
    logic              is_store;
    logic              is_branch;
    logic              mispredict;
    logic [XLEN-1:0]   target;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit_if.sv
// Dispatch, writeback and commit signals between the ROB and its neighbours.
interface rob_commit_if;
  import rob_pkg::*;

  logic              disp_valid;
  logic              disp_ready;
  logic [AREG_W-1:0] disp_areg;
  logic [PREG_W-1:0] disp_prd;
  logic [PREG_W-1:0] disp_old_prd;
  logic              disp_is_store;
  logic              disp_is_branch;
  logic [TAG_W-1:0]  disp_tag;
  logic              alu_wb_valid;
  logic [TAG_W-1:0]  alu_cdb_tag;
  logic              lsu_wb_valid;
  logic [TAG_W-1:0]  lsu_cdb_tag;
  logic              branch_wb_valid;
  logic [TAG_W-1:0]  branch_cdb_tag;
  logic              branch_taken;
  logic [XLEN-1:0]   branch_target_addr;
  logic              commit_valid;
  logic [AREG_W-1:0] commit_areg;
  logic [PREG_W-1:0] commit_prd;
  logic [PREG_W-1:0] commit_old_prd;
  logic              commit_store;
  logic              flush;
  logic [XLEN-1:0]   redirect_pc;
  logic              rob_empty;

  modport master (
    output disp_valid, disp_areg, disp_prd, disp_old_prd, disp_is_store, disp_is_branch,
    output alu_wb_valid, alu_cdb_tag, lsu_wb_valid, lsu_cdb_tag,
    output branch_wb_valid, branch_cdb_tag, branch_taken, branch_target_addr,
    input  disp_ready, disp_tag, commit_valid, commit_areg, commit_prd, commit_old_prd,
    input  commit_store, flush, redirect_pc, rob_empty
  );

  modport slave (
    input  disp_valid, disp_areg, disp_prd, disp_old_prd, disp_is_store, disp_is_branch,
    input  alu_wb_valid, alu_cdb_tag, lsu_wb_valid, lsu_cdb_tag,
    input  branch_wb_valid, branch_cdb_tag, branch_taken, branch_target_addr,
    output disp_ready, disp_tag, commit_valid, commit_areg, commit_prd, commit_old_prd,
    output commit_store, flush, redirect_pc, rob_empty
  );

endinterface

// File: rtl/rob_commit.sv
// In-order reorder buffer: allocates tags, marks writebacks done, retires one per cycle.
// Optional ROB_WB_BYPASS_EN lets a writeback to the head retire on the same edge.
module rob_commit
  import rob_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  rob_commit_if.slave  bus
);

  rob_entry_t rob_q [DEPTH];
  rob_entry_t rob_d [DEPTH];

  logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;
  logic              commit_valid_q, commit_valid_d;
  logic [AREG_W-1:0] commit_areg_q, commit_areg_d;
  logic [PREG_W-1:0] commit_prd_q, commit_prd_d;
  logic [PREG_W-1:0] commit_old_prd_q, commit_old_prd_d;
  logic              commit_store_q, commit_store_d;
  logic              flush_q, flush_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;

  logic [DEPTH-1:0]  alu_hit, lsu_hit, br_hit;
  rob_entry_t        head_e;
  logic              head_done, head_misp;
  logic [XLEN-1:0]   head_target;
  logic              disp_ready, disp_fire, commit_fire;

  // Writebacks only land on live entries and are dropped during recovery.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign alu_hit[gi] = bus.alu_wb_valid && (bus.alu_cdb_tag == TAG_W'(gi))
                           && rob_q[gi].valid && !flush_q;
      assign lsu_hit[gi] = bus.lsu_wb_valid && (bus.lsu_cdb_tag == TAG_W'(gi))
                           && rob_q[gi].valid && !flush_q;
      assign br_hit[gi]  = bus.branch_wb_valid && (bus.branch_cdb_tag == TAG_W'(gi))
                           && rob_q[gi].valid && !flush_q;
    end
  endgenerate

  assign head_e = rob_q[head_q];

`ifdef ROB_WB_BYPASS_EN
  assign head_done   = head_e.done | alu_hit[head_q] | lsu_hit[head_q] | br_hit[head_q];
  assign head_misp   = br_hit[head_q] ? bus.branch_taken : head_e.mispredict;
  assign head_target = br_hit[head_q] ? bus.branch_target_addr : head_e.target;
`else
  assign head_done   = head_e.done;
  assign head_misp   = head_e.mispredict;
  assign head_target = head_e.target;
`endif

  assign disp_ready  = (count_q != (TAG_W+1)'(DEPTH)) && !flush_q;
  assign disp_fire   = bus.disp_valid && disp_ready;
  assign commit_fire = head_e.valid && head_done && !flush_q;

  always_comb begin
    rob_d = rob_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_hit[i] || lsu_hit[i]) rob_d[i].done = 1'b1;
      if (br_hit[i]) begin
        rob_d[i].done       = 1'b1;
        rob_d[i].mispredict = bus.branch_taken;
        rob_d[i].target     = bus.branch_target_addr;
      end
    end
    if (commit_fire) rob_d[head_q] = '0;
    if (disp_fire) begin
      rob_d[tail_q]           = '0;
      rob_d[tail_q].valid     = 1'b1;
      rob_d[tail_q].areg      = bus.disp_areg;
      rob_d[tail_q].prd       = bus.disp_prd;
      rob_d[tail_q].old_prd   = bus.disp_old_prd;
      rob_d[tail_q].is_store  = bus.disp_is_store;
      rob_d[tail_q].is_branch = bus.disp_is_branch;
    end
    head_d  = head_q + TAG_W'(commit_fire);
    tail_d  = tail_q + TAG_W'(disp_fire);
    count_d = count_q + (TAG_W+1)'(disp_fire) - (TAG_W+1)'(commit_fire);

    commit_valid_d   = commit_fire;
    commit_areg_d    = commit_fire ? head_e.areg : '0;
    commit_prd_d     = commit_fire ? head_e.prd : '0;
    commit_old_prd_d = commit_fire ? head_e.old_prd : '0;
    commit_store_d   = commit_fire && head_e.is_store;
    flush_d          = commit_fire && head_e.is_branch && head_misp;
    redirect_pc_d    = flush_d ? head_target : '0;

    // The flush cycle wipes every younger entry and restarts tags at 0.
    if (flush_q) begin
      for (int i = 0; i < DEPTH; i++) rob_d[i] = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) rob_q[i] <= '0;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      commit_valid_q   <= 1'b0;
      commit_areg_q    <= '0;
      commit_prd_q     <= '0;
      commit_old_prd_q <= '0;
      commit_store_q   <= 1'b0;
      flush_q          <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      rob_q            <= rob_d;
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      commit_valid_q   <= commit_valid_d;
      commit_areg_q    <= commit_areg_d;
      commit_prd_q     <= commit_prd_d;
      commit_old_prd_q <= commit_old_prd_d;
      commit_store_q   <= commit_store_d;
      flush_q          <= flush_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign bus.disp_ready     = disp_ready;
  assign bus.disp_tag       = tail_q;
  assign bus.commit_valid   = commit_valid_q;
  assign bus.commit_areg    = commit_areg_q;
  assign bus.commit_prd     = commit_prd_q;
  assign bus.commit_old_prd = commit_old_prd_q;
  assign bus.commit_store   = commit_store_q;
  assign bus.flush          = flush_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.rob_empty      = (count_q == '0);

endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: dispatch table plus an in-order commit scoreboard.
module tb_rob_commit;
  import rob_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rob_commit_if bus ();
  rob_commit dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [4:0]  areg;
    logic [6:0]  prd;
    logic [6:0]  old_prd;
    logic        is_store;
    logic        is_branch;
    logic [3:0]  exp_tag;
    logic        exp_commit;
    logic        exp_flush;
    logic [31:0] exp_redirect;
  } vec_t;

  typedef struct packed {
    logic [4:0]  areg;
    logic [6:0]  prd;
    logic [6:0]  old_prd;
    logic        store;
    logic        flush;
    logic [31:0] redirect;
  } exp_t;

  vec_t vecs [11];
  exp_t sb [$];
  int checks = 0;
  int errors = 0;
  int n_commits = 0;
  logic last_flush = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one edge and score any commit the DUT presents.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    last_flush = bus.flush;
    if (bus.commit_valid) begin
      n_commits++;
      $display("commit areg=%0d prd=%0d old_prd=%0d store=%0b flush=%0b pc=0x%0h",
               bus.commit_areg, bus.commit_prd, bus.commit_old_prd, bus.commit_store,
               bus.flush, bus.redirect_pc);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: got areg=%0d prd=%0d, expected no commit",
                 bus.commit_areg, bus.commit_prd);
      end else begin
        e = sb.pop_front();
        check("commit_areg", 32'(bus.commit_areg), 32'(e.areg));
        check("commit_prd", 32'(bus.commit_prd), 32'(e.prd));
        check("commit_old_prd", 32'(bus.commit_old_prd), 32'(e.old_prd));
        check("commit_store", 32'(bus.commit_store), 32'(e.store));
        check("flush", 32'(bus.flush), 32'(e.flush));
        check("redirect_pc", bus.redirect_pc, e.redirect);
      end
    end else if (bus.flush) begin
      check("flush_without_commit", 32'(bus.flush), 32'd0);
    end
  endtask

  task automatic dispatch(input vec_t v);
    bus.disp_valid     = 1'b1;
    bus.disp_areg      = v.areg;
    bus.disp_prd       = v.prd;
    bus.disp_old_prd   = v.old_prd;
    bus.disp_is_store  = v.is_store;
    bus.disp_is_branch = v.is_branch;
    check("disp_ready", 32'(bus.disp_ready), 32'd1);
    check("disp_tag", 32'(bus.disp_tag), 32'(v.exp_tag));
    if (v.exp_commit)
      sb.push_back('{v.areg, v.prd, v.old_prd, v.is_store, v.exp_flush, v.exp_redirect});
    $display("dispatch tag=%0d areg=%0d prd=%0d old_prd=%0d", bus.disp_tag, v.areg, v.prd, v.old_prd);
    tick();
    bus.disp_valid = 1'b0;
  endtask

  // port: 0 = ALU, 1 = LSU, 2 = branch
  task automatic wb(input int port, input logic [3:0] tag, input logic taken, input logic [31:0] tgt);
    case (port)
      0: begin bus.alu_wb_valid = 1'b1; bus.alu_cdb_tag = tag; end
      1: begin bus.lsu_wb_valid = 1'b1; bus.lsu_cdb_tag = tag; end
      default: begin
        bus.branch_wb_valid = 1'b1; bus.branch_cdb_tag = tag;
        bus.branch_taken = taken; bus.branch_target_addr = tgt;
      end
    endcase
    $display("writeback port=%0d tag=%0d", port, tag);
    tick();
    bus.alu_wb_valid = 1'b0;
    bus.lsu_wb_valid = 1'b0;
    bus.branch_wb_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while (sb.size() != 0 && t < budget) begin
      tick();
      t++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_commit(input int n0, input int budget);
    int t = 0;
    while (n_commits == n0 && t < budget) begin
      tick();
      t++;
    end
    check("commit_seen", 32'(n_commits - n0), 32'd1);
  endtask

  initial begin
    int n0;
    vec_t v;
    vecs[0]  = '{5'd1, 7'd32, 7'd1,  1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{5'd2, 7'd33, 7'd2,  1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 32'h0};
    vecs[2]  = '{5'd3, 7'd34, 7'd3,  1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 32'h0};
    vecs[3]  = '{5'd0, 7'd0,  7'd0,  1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 32'h0};
    vecs[4]  = '{5'd5, 7'd35, 7'd12, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 32'h0};
    vecs[5]  = '{5'd0, 7'd0,  7'd0,  1'b0, 1'b1, 4'd5, 1'b1, 1'b1, 32'h1C};
    vecs[6]  = '{5'd6, 7'd36, 7'd6,  1'b0, 1'b0, 4'd6, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{5'd7, 7'd37, 7'd7,  1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{5'd8, 7'd38, 7'd8,  1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 32'h0};
    vecs[9]  = '{5'd9, 7'd39, 7'd9,  1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 32'h0};
    vecs[10] = '{5'd0, 7'd0,  7'd0,  1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 32'h0};

    rst = 1'b1;
    bus.disp_valid = 1'b0; bus.disp_areg = '0; bus.disp_prd = '0; bus.disp_old_prd = '0;
    bus.disp_is_store = 1'b0; bus.disp_is_branch = 1'b0;
    bus.alu_wb_valid = 1'b0; bus.alu_cdb_tag = '0;
    bus.lsu_wb_valid = 1'b0; bus.lsu_cdb_tag = '0;
    bus.branch_wb_valid = 1'b0; bus.branch_cdb_tag = '0;
    bus.branch_taken = 1'b0; bus.branch_target_addr = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_disp_ready", 32'(bus.disp_ready), 32'd1);
    check("rst_disp_tag", 32'(bus.disp_tag), 32'd0);
    check("rst_commit_valid", 32'(bus.commit_valid), 32'd0);
    check("rst_flush", 32'(bus.flush), 32'd0);
    check("rst_redirect", bus.redirect_pc, 32'd0);
    check("rst_rob_empty", 32'(bus.rob_empty), 32'd1);

    // Out-of-order writeback, in-order commit.
    for (int i = 0; i < 3; i++) dispatch(vecs[i]);
    check("t1_not_empty", 32'(bus.rob_empty), 32'd0);
    wb(0, 4'd2, 1'b0, 32'h0);
    wb(0, 4'd0, 1'b0, 32'h0);
`ifdef ROB_WB_BYPASS_EN
    check("t1_latency", 32'(bus.commit_valid), 32'd1);
`else
    check("t1_latency", 32'(bus.commit_valid), 32'd0);
`endif
    wb(0, 4'd1, 1'b0, 32'h0);
    drain(10);
    tick();
    check("t1_rob_empty", 32'(bus.rob_empty), 32'd1);

    // Store then load through the LSU port.
    for (int i = 3; i < 5; i++) dispatch(vecs[i]);
    wb(1, 4'd3, 1'b0, 32'h0);
    wb(1, 4'd4, 1'b0, 32'h0);
    drain(10);

    // Taken branch flushes younger work; a dispatch in the flush cycle is dropped.
    for (int i = 5; i < 8; i++) dispatch(vecs[i]);
    wb(0, 4'd6, 1'b0, 32'h0);
    wb(0, 4'd7, 1'b0, 32'h0);
    wb(2, 4'd5, 1'b1, 32'h1C);
    for (int t = 0; t < 10 && !last_flush; t++) tick();
    check("br_flush_seen", 32'(last_flush), 32'd1);
    check("br_flush_ready", 32'(bus.disp_ready), 32'd0);
    bus.disp_valid = 1'b1; bus.disp_areg = 5'd31; bus.disp_prd = 7'd99;
    tick();
    bus.disp_valid = 1'b0;
    check("br_post_flush", 32'(bus.flush), 32'd0);
    check("br_empty", 32'(bus.rob_empty), 32'd1);
    check("br_tag_restart", 32'(bus.disp_tag), 32'd0);
    for (int t = 0; t < 4; t++) tick();
    check("br_sb_empty", 32'(sb.size()), 32'd0);

    // Three ports fire in one cycle: back-to-back commits.
    for (int i = 8; i < 11; i++) dispatch(vecs[i]);
    n0 = n_commits;
    bus.alu_wb_valid = 1'b1; bus.alu_cdb_tag = 4'd0;
    bus.lsu_wb_valid = 1'b1; bus.lsu_cdb_tag = 4'd1;
    bus.branch_wb_valid = 1'b1; bus.branch_cdb_tag = 4'd2;
    bus.branch_taken = 1'b0; bus.branch_target_addr = 32'h40;
    tick();
    bus.alu_wb_valid = 1'b0; bus.lsu_wb_valid = 1'b0; bus.branch_wb_valid = 1'b0;
    wait_commit(n0, 5);
    tick();
    check("sc_commit2", 32'(bus.commit_valid), 32'd1);
    tick();
    check("sc_commit3", 32'(bus.commit_valid), 32'd1);
    tick();
    check("sc_idle", 32'(bus.commit_valid), 32'd0);
    check("sc_empty", 32'(bus.rob_empty), 32'd1);

    // Reset with five entries in flight.
    for (int i = 0; i < 5; i++) begin
      v = '{5'(i + 10), 7'(50 + i), 7'(70 + i), 1'b0, 1'b0, 4'(3 + i), 1'b0, 1'b0, 32'h0};
      dispatch(v);
    end
    wb(0, 4'd3, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_commit", 32'(bus.commit_valid), 32'd0);
    check("mid_rst_empty", 32'(bus.rob_empty), 32'd1);
    check("mid_rst_tag", 32'(bus.disp_tag), 32'd0);
    for (int i = 0; i < 8; i++) wb(0, 4'(i), 1'b0, 32'h0);
    tick();
    check("mid_rst_still_empty", 32'(bus.rob_empty), 32'd1);

    // Fill to 16, try an over-full dispatch, then free one slot and wrap.
    for (int i = 0; i < 16; i++) begin
      v = '{5'(i + 1), 7'(40 + i), 7'(60 + i), 1'b0, 1'b0, 4'(i), 1'b1, 1'b0, 32'h0};
      dispatch(v);
    end
    check("full_ready", 32'(bus.disp_ready), 32'd0);
    check("full_not_empty", 32'(bus.rob_empty), 32'd0);
    bus.disp_valid = 1'b1; bus.disp_areg = 5'd30; bus.disp_prd = 7'd120;
    tick();
    bus.disp_valid = 1'b0;
    check("full_tag_hold", 32'(bus.disp_tag), 32'd0);
    n0 = n_commits;
    wb(0, 4'd0, 1'b0, 32'h0);
    wait_commit(n0, 5);
    check("wrap_ready", 32'(bus.disp_ready), 32'd1);
    check("wrap_tag", 32'(bus.disp_tag), 32'd0);
    dispatch('{5'd9, 7'd99, 7'd77, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 32'h0});
    for (int i = 1; i < 16; i++) wb(0, 4'(i), 1'b0, 32'h0);
    wb(0, 4'd0, 1'b0, 32'h0);
    drain(40);
    tick();
    check("final_empty", 32'(bus.rob_empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Reorder buffer: the receiving end of the ALU, LSU and branch writeback/CDB ports.
- Allocates one entry per dispatched instruction and returns its 4-bit tag, which is the value every FU later drives on its CDB tag output.
- Marks entries done on writeback and retires them strictly in order, one per cycle.
- Drives free-list release, store release and mispredict flush/redirect to the front end.

Parameters:
- DEPTH, 16, number of entries; the tag is the entry index.
- TAG_W, 4, log2(DEPTH).
- PREG_W, 7, physical register index width.
- XLEN, 32, PC/target width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- disp_valid  in  1  dispatch request
- disp_ready  out  1  entry available
- disp_areg  in  5  architectural rd (0 = no write)
- disp_prd  in  PREG_W  new physical rd
- disp_old_prd  in  PREG_W  previous mapping of rd
- disp_is_store  in  1  store instruction
- disp_is_branch  in  1  branch instruction
- disp_tag  out  TAG_W  tag assigned on the handshake cycle (= tail)
- alu_wb_valid  in  1  ALU writeback
- alu_cdb_tag  in  TAG_W  ALU tag
- lsu_wb_valid  in  1  LSU writeback
- lsu_cdb_tag  in  TAG_W  LSU tag
- branch_wb_valid  in  1  branch writeback
- branch_cdb_tag  in  TAG_W  branch tag
- branch_taken  in  1  resolved direction
- branch_target_addr  in  XLEN  resolved target
- commit_valid  out  1  an entry retires this cycle
- commit_areg  out  5  retiring arch rd
- commit_prd  out  PREG_W  retiring physical rd
- commit_old_prd  out  PREG_W  to free list when commit_areg != 0
- commit_store  out  1  release head store to memory
- flush  out  1  mispredict recovery pulse
- redirect_pc  out  XLEN  fetch target, valid when flush = 1
- rob_empty  out  1  no valid entries

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - head = tail = 0, count = 0, all valid/done cleared.
  - Outputs: disp_ready=1, disp_tag=0, commit_*=0, flush=0, redirect_pc=0, rob_empty=1.
- Tag numbering: the first tag after reset or flush is 0.
- Dispatch:
  - Handshake = disp_valid & disp_ready.
  - The entry at tail is written: valid=1, done=0, fields latched, mispredict=0.
  - tail increments mod DEPTH.
  - disp_ready = (count != DEPTH) & !flush. No same-cycle credit is taken from a commit.
- Writeback:
  - Each valid port sets done[tag] at the posedge; all three ports may fire in the same cycle with distinct tags.
  - Branch writeback also latches taken/target into the entry; mispredict = branch_taken (predict-not-taken front end).
  - Writeback to an entry with valid=0 is ignored.
  - Writeback in the flush cycle is ignored.
- Commit (registered outputs):
  - Condition: head entry valid & done.
  - Next cycle: commit_valid=1 with that entry's fields, valid cleared, head++ mod DEPTH, count--.
  - Latency: writeback at edge N, commit_valid high in the cycle after edge N+1.
  - commit_store = commit_valid & is_store.
- Mispredict:
  - When the retiring head is a branch with mispredict=1, flush=1 and redirect_pc=target in the same cycle as its commit_valid.
  - Flush clears all entries and sets head=tail=count=0 on the next edge.
  - Any dispatch attempted in the flush cycle is dropped (disp_ready=0).
- Count:
  - Simultaneous dispatch and commit leaves count unchanged.
  - count range 0..DEPTH; head==tail is disambiguated by count.
- rob_empty = (count == 0).
- rst mid-operation discards all in-flight state; no commit or flush is emitted.

Optional Feature:
- Macro: ROB_WB_BYPASS_EN.
- Defined: a writeback whose tag equals head in the current cycle makes head commit-eligible that same edge, saving one cycle of writeback-to-commit latency. A branch bypass uses the live branch_taken/branch_target_addr values.
- Undefined: done must be registered first; commit occurs one cycle later.

Decomposition:
- Shared package (rob_pkg): TAG_W, DEPTH and a rob_entry_t struct {valid, done, areg, prd, old_prd, is_store, is_branch, mispredict, target}.
- No sub-module: one entry array, head/tail/count and a commit register stage.

Test Plan:
- Dispatch 3 ALU ops (tags 0,1,2), write back tags 2,0,1 on separate cycles -> commits in order 0,1,2; commit_old_prd matches the dispatched values; rob_empty=1 afterwards.
- Dispatch 16 ops -> disp_ready=0 at count=16. Write back tag 0 -> commit; disp_ready=1 and the next disp_tag=0 (wrap).
- SW tag 3 then LW tag 4; LSU writeback of both -> commit_store=1 only on the tag-3 commit; LW commit_prd=35.
- Branch tag 5, taken, target 0x1C, with tags 6,7 dispatched -> flush=1 and redirect_pc=0x1C at tag-5 commit; tags 6,7 never commit; next disp_tag=0.
- Same-cycle ALU/LSU/branch writebacks to tags 0,1,2 -> three consecutive commits with no bubbles.
- Assert rst with 5 entries pending -> no commits afterwards; rob_empty=1; disp_tag=0.
